alu_seq_acc: RTL and testbench

//  Parametrised sequential ALU with accumulator; next generation of the 2-bit combinational

---
 rtl/alu_seq_acc_if.sv | 37 +++
 rtl/alu_seq_acc.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq_acc.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_acc_if.sv
// rtl/alu_seq_acc_if.sv - request/result bundle for alu_seq_acc; ALU_WIDE_RESULT_EN adds result_hi
interface alu_seq_acc_if #(
    parameter int N = 16
);
    logic         start;
    logic [3:0]   op;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [1:0]   b_sel;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [N-1:0] acc;
    logic         carry;
    logic         zero;
    logic         dz;
    logic         illegal;
`ifdef ALU_WIDE_RESULT_EN
    logic [N-1:0] result_hi;
`endif

    modport master (
        output start, op, a_in, b_in, b_sel,
        input  busy, done, result, acc, carry, zero, dz, illegal
`ifdef ALU_WIDE_RESULT_EN
        , input result_hi
`endif
    );

    modport slave (
        input  start, op, a_in, b_in, b_sel,
        output busy, done, result, acc, carry, zero, dz, illegal
`ifdef ALU_WIDE_RESULT_EN
        , output result_hi
`endif
    );
endinterface

// File: rtl/alu_seq_acc.sv
// rtl/alu_seq_acc.sv - sequential ALU with accumulator, iterative MUL/DIV
// ALU_WIDE_RESULT_EN: drives result_hi (MUL upper half / DIV remainder)
module alu_seq_acc #(
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_acc_if.slave  bus
);
    localparam int SW = $clog2(N);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_XNOR  = 4'd5;
    localparam logic [3:0] OP_NOR   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_DIV   = 4'd9;
    localparam logic [3:0] OP_PASSA = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

    state_t        state, state_nx;
    logic [3:0]    op_r;
    logic [N-1:0]  a_r, b_r;
    logic [N-1:0]  hi_r, lo_r;
    logic [SW-1:0] cnt;
    logic [N-1:0]  b_src;
    logic          accept, iter_op;

    logic [N-1:0]  result_r, acc_r;
    logic          done_r, carry_r, zero_r, dz_r, ill_r;

    logic [N:0]    mul_sum, div_sh, div_diff;
    logic          div_ge;
    logic [N:0]    add_s, sub_s;
    logic [N-1:0]  fin_res;
    logic          fin_carry, fin_dz, fin_ill;
`ifdef ALU_WIDE_RESULT_EN
    logic [N-1:0]  fin_hi, result_hi_r;
`endif

    assign accept  = (state == S_IDLE) && bus.start;
    assign iter_op = (bus.op == OP_MUL) || (bus.op == OP_DIV);

    always_comb begin
        b_src = '0;
        case (bus.b_sel)
            2'd0:    b_src = '0;
            2'd1:    b_src = bus.b_in;
            2'd2:    b_src = acc_r;
            default: b_src = b_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = iter_op ? S_ITER : S_FIN;
            S_ITER:  if (cnt == '0) state_nx = S_FIN;
            default: state_nx = S_IDLE;
        endcase
    end

    // One iteration step: hi/lo hold product halves for MUL, remainder/quotient for DIV
    assign mul_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
    assign div_sh   = {hi_r, lo_r[N-1]};
    assign div_ge   = div_sh >= {1'b0, b_r};
    assign div_diff = div_sh - {1'b0, b_r};

    assign add_s = {1'b0, a_r} + {1'b0, b_r};
    assign sub_s = {1'b0, a_r} - {1'b0, b_r};

    always_comb begin
        fin_res   = '0;
        fin_carry = 1'b0;
        fin_dz    = 1'b0;
        fin_ill   = 1'b0;
`ifdef ALU_WIDE_RESULT_EN
        fin_hi    = '0;
`endif
        case (op_r)
            OP_ADD:   begin fin_res = add_s[N-1:0]; fin_carry = add_s[N]; end
            OP_SUB:   begin fin_res = sub_s[N-1:0]; fin_carry = ~sub_s[N]; end
            OP_AND:   fin_res = a_r & b_r;
            OP_OR:    fin_res = a_r | b_r;
            OP_XOR:   fin_res = a_r ^ b_r;
            OP_XNOR:  fin_res = ~(a_r ^ b_r);
            OP_NOR:   fin_res = ~(a_r | b_r);
            OP_SHR:   fin_res = a_r >> b_r[SW-1:0];
            OP_PASSA: fin_res = a_r;
            OP_MUL: begin
                fin_res = lo_r;
`ifdef ALU_WIDE_RESULT_EN
                fin_hi  = hi_r;
`endif
            end
            OP_DIV: begin
                // B==0 needs no special case: every step subtracts, giving all-ones quotient and rem=A
                fin_res = lo_r;
                fin_dz  = (b_r == '0);
`ifdef ALU_WIDE_RESULT_EN
                fin_hi  = hi_r;
`endif
            end
            default:  fin_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            cnt      <= '0;
            result_r <= '0;
            acc_r    <= '0;
            done_r   <= 1'b0;
            carry_r  <= 1'b0;
            zero_r   <= 1'b0;
            dz_r     <= 1'b0;
            ill_r    <= 1'b0;
`ifdef ALU_WIDE_RESULT_EN
            result_hi_r <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r <= bus.op;
                        a_r  <= bus.a_in;
                        b_r  <= b_src;
                        hi_r <= '0;
                        lo_r <= bus.a_in;
                        cnt  <= SW'(N - 1);
                    end
                end
                S_ITER: begin
                    cnt <= cnt - 1'b1;
                    if (op_r == OP_MUL) begin
                        hi_r <= mul_sum[N:1];
                        lo_r <= {mul_sum[0], lo_r[N-1:1]};
                    end else begin
                        hi_r <= div_ge ? div_diff[N-1:0] : div_sh[N-1:0];
                        lo_r <= {lo_r[N-2:0], div_ge};
                    end
                end
                default: begin
                    result_r <= fin_res;
                    acc_r    <= fin_res;
                    done_r   <= 1'b1;
                    carry_r  <= fin_carry;
                    zero_r   <= (fin_res == '0);
                    dz_r     <= fin_dz;
                    ill_r    <= fin_ill;
`ifdef ALU_WIDE_RESULT_EN
                    result_hi_r <= fin_hi;
`endif
                end
            endcase
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = done_r;
    assign bus.result  = result_r;
    assign bus.acc     = acc_r;
    assign bus.carry   = carry_r;
    assign bus.zero    = zero_r;
    assign bus.dz      = dz_r;
    assign bus.illegal = ill_r;
`ifdef ALU_WIDE_RESULT_EN
    assign bus.result_hi = result_hi_r;
`endif
endmodule

// File: tb/tb_alu_seq_acc.sv
// tb/tb_alu_seq_acc.sv - scoreboard bench for alu_seq_acc
module tb_alu_seq_acc;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_acc_if #(.N(N)) bus();
    alu_seq_acc #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] res;
        logic        carry;
        logic        zero;
        logic        dz;
        logic        ill;
        logic [15:0] hi;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result",  32'(bus.result),  32'(mon_e.res));
                chk("acc",     32'(bus.acc),     32'(mon_e.res));
                chk("carry",   32'(bus.carry),   32'(mon_e.carry));
                chk("zero",    32'(bus.zero),    32'(mon_e.zero));
                chk("dz",      32'(bus.dz),      32'(mon_e.dz));
                chk("illegal", 32'(bus.illegal), 32'(mon_e.ill));
                chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
`ifdef ALU_WIDE_RESULT_EN
                chk("result_hi", 32'(bus.result_hi), 32'(mon_e.hi));
`endif
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] bs, input logic [15:0] r, input logic c,
                         input logic z, input logic d, input logic il, input logic [15:0] h,
                         input int lat);
        exp_t e;
        wait_idle();
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.b_sel = bs;
        e.res = r; e.carry = c; e.zero = z; e.dz = d; e.ill = il; e.hi = h;
        e.lat = lat; e.t0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.a_in = '0; bus.b_in = '0; bus.b_sel = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_acc",    32'(bus.acc),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        //     op     a        b        bs    res      c  z  d  il hi       lat
        issue(4'd0,  16'hFFFF, 16'h0001, 2'd1, 16'h0000, 1, 1, 0, 0, 16'h0000, 1);
        issue(4'd8,  16'h1234, 16'h0010, 2'd1, 16'h2340, 0, 0, 0, 0, 16'h0001, 17);
        issue(4'd9,  16'd100,  16'd7,    2'd1, 16'h000E, 0, 0, 0, 0, 16'h0002, 17);
        issue(4'd9,  16'h0050, 16'h1234, 2'd0, 16'hFFFF, 0, 0, 1, 0, 16'h0050, 17);
        issue(4'd7,  16'h8000, 16'hFF0F, 2'd1, 16'h0001, 0, 0, 0, 0, 16'h0000, 1);
        issue(4'd12, 16'h1234, 16'h5678, 2'd1, 16'h0000, 0, 1, 0, 1, 16'h0000, 1);
        issue(4'd2,  16'hF0F0, 16'hFF00, 2'd1, 16'hF000, 0, 0, 0, 0, 16'h0000, 1);
        issue(4'd3,  16'hF0F0, 16'h0F00, 2'd1, 16'hFFF0, 0, 0, 0, 0, 16'h0000, 1);
        issue(4'd4,  16'hF0F0, 16'hFF00, 2'd1, 16'h0FF0, 0, 0, 0, 0, 16'h0000, 1);
        issue(4'd5,  16'hF0F0, 16'hFF00, 2'd1, 16'hF00F, 0, 0, 0, 0, 16'h0000, 1);
        issue(4'd6,  16'hF0F0, 16'hFF00, 2'd1, 16'h000F, 0, 0, 0, 0, 16'h0000, 1);
        issue(4'd10, 16'h1357, 16'hFFFF, 2'd1, 16'h1357, 0, 0, 0, 0, 16'h0000, 1);
        issue(4'd1,  16'd5,    16'd3,    2'd1, 16'h0002, 1, 0, 0, 0, 16'h0000, 1);
        issue(4'd1,  16'd9,    16'd9,    2'd1, 16'h0000, 1, 1, 0, 0, 16'h0000, 1);

        wait_idle();
        @(negedge clk);
        do_reset();
        chk("rst2_acc", 32'(bus.acc), 32'd0);
        issue(4'd0, 16'd5, 16'hAAAA, 2'd2, 16'd5,  0, 0, 0, 0, 16'h0000, 1);
        issue(4'd0, 16'd5, 16'hAAAA, 2'd2, 16'd10, 0, 0, 0, 0, 16'h0000, 1);
        issue(4'd0, 16'd5, 16'hAAAA, 2'd2, 16'd15, 0, 0, 0, 0, 16'h0000, 1);

        // start while busy must not disturb the latched B (checked via b_sel=3)
        issue(4'd8, 16'd2, 16'd3, 2'd1, 16'd6, 0, 0, 0, 0, 16'h0000, 17);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        bus.start = 1'b1; bus.op = 4'd0; bus.a_in = 16'h0007; bus.b_in = 16'h5555; bus.b_sel = 2'd1;
        @(negedge clk);
        bus.start = 1'b0;
        issue(4'd0, 16'd1, 16'h5555, 2'd3, 16'd4, 0, 0, 0, 0, 16'h0000, 1);

        // reset during MUL iteration aborts with no result
        issue(4'd8, 16'h1234, 16'h0003, 2'd1, 16'h369C, 0, 0, 0, 0, 16'h0000, 17);
        repeat (7) @(negedge clk);
        chk("iter_busy", 32'(bus.busy), 32'd1);
        do_reset();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_acc",  32'(bus.acc),  32'd0);
        issue(4'd1, 16'd3, 16'd5, 2'd1, 16'hFFFE, 0, 0, 0, 0, 16'h0000, 1);

        begin
            int n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
